seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_pattern_tx.sv | 123 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Serial pattern transmitter bus: request, latched parameters
// and the registered serial stream with its status flags.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             x_out;
  logic             sof;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, reps, gap,
    input  x_out, sof, busy, done
  );

  modport slave (
    input  start, abort, pattern, reps, gap,
    output x_out, sof, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame generator: sends a latched pattern MSB first,
// reps+1 times with optional idle-0 gaps between frames.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_pattern_tx_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE, SEND, GAP, DONE
  } state_t;

  state_t           st_q, st_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [CNT_W-1:0] frm_q, frm_n;
  logic [CNT_W-1:0] gap_q, gap_n;
  logic [CNT_W-1:0] lgap_q, lgap_n;
  logic             x_q, sof_q, busy_q, done_q;
  logic             x_d, sof_d, busy_d, done_d;

  always_comb begin
    st_n   = st_q;
    sh_n   = sh_q;
    pat_n  = pat_q;
    bit_n  = bit_q;
    frm_n  = frm_q;
    gap_n  = gap_q;
    lgap_n = lgap_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          st_n   = SEND;
          sh_n   = bus.pattern;
          pat_n  = bus.pattern;
          bit_n  = LAST;
          frm_n  = bus.reps;
          lgap_n = bus.gap;
        end
      end
      SEND: begin
        if (bus.abort) begin
          st_n = IDLE;
        end else if (bit_q != '0) begin
          sh_n  = {sh_q[WIDTH-2:0], 1'b0};
          bit_n = bit_q - BW'(1);
        end else if (frm_q == '0) begin
          st_n = DONE;
        end else begin
          frm_n = frm_q - CNT_W'(1);
          if (lgap_q != '0) begin
            st_n  = GAP;
            gap_n = lgap_q;
          end else begin
            sh_n  = pat_q;
            bit_n = LAST;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          st_n = IDLE;
        end else if (gap_q == CNT_W'(1)) begin
          st_n  = SEND;
          sh_n  = pat_q;
          bit_n = LAST;
        end else begin
          gap_n = gap_q - CNT_W'(1);
        end
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Output flops take the decode of the next state, so they
  // line up with the state they describe.
  always_comb begin
    x_d    = (st_n == SEND) && sh_n[WIDTH-1];
    sof_d  = (st_n == SEND) && (bit_n == LAST);
    busy_d = (st_n == SEND) || (st_n == GAP);
    done_d = (st_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      sh_q   <= '0;
      pat_q  <= '0;
      bit_q  <= '0;
      frm_q  <= '0;
      gap_q  <= '0;
      lgap_q <= '0;
      x_q    <= 1'b0;
      sof_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      sh_q   <= sh_n;
      pat_q  <= pat_n;
      bit_q  <= bit_n;
      frm_q  <= frm_n;
      gap_q  <= gap_n;
      lgap_q <= lgap_n;
      x_q    <= x_d;
      sof_q  <= sof_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.x_out = x_q;
  assign bus.sof   = sof_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a 1101 Moore
// detector fed from x_out.
module tb_seq_pattern_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   det_state;
  int   det_cnt;

  seq_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) bus ();

  seq_pattern_tx #(.WIDTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping 1101 Moore detector; state 4 is detect.
  always @(posedge clk) begin
    if (rst) begin
      det_state <= 0;
    end else begin
      case (det_state)
        0: det_state <= bus.x_out ? 1 : 0;
        1: det_state <= bus.x_out ? 2 : 0;
        2: det_state <= bus.x_out ? 2 : 3;
        3: det_state <= bus.x_out ? 4 : 0;
        default: det_state <= bus.x_out ? 2 : 0;
      endcase
      if (det_state == 3 && bus.x_out)
        det_cnt <= det_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    #3;
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async obs=%b exp=0000", obs);
    end
    step();
    step();
    rst = 1'b0;
    step();
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle obs=%b exp=0000", obs);
    end
  endtask

  task automatic test_single();
    logic [5:0] ex = 6'b110100;
    logic [5:0] es = 6'b100000;
    logic [5:0] eb = 6'b111100;
    logic [5:0] ed = 6'b000010;
    logic [3:0] obs, exp_v;
    int d0;
    d0 = det_cnt;
    bus.pattern = 4'b1101;
    bus.reps = 4'd0;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.pattern = 4'b0000;
    bus.reps = 4'd3;
    bus.gap = 4'd5;
    for (int i = 1; i <= 6; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      exp_v = {ex[6-i], es[6-i], eb[6-i], ed[6-i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single c%0d obs=%b exp=%b", i, obs, exp_v);
      end
      step();
    end
    checks++;
    if (det_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_det got=%0d exp=1", det_cnt - d0);
    end
  endtask

  task automatic test_gap();
    logic [11:0] ex = 12'b110100110100;
    logic [11:0] es = 12'b100000100000;
    logic [11:0] eb = 12'b111111111100;
    logic [11:0] ed = 12'b000000000010;
    logic [3:0] obs, exp_v;
    int d0;
    d0 = det_cnt;
    bus.pattern = 4'b1101;
    bus.reps = 4'd1;
    bus.gap = 4'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      exp_v = {ex[12-i], es[12-i], eb[12-i], ed[12-i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL gap c%0d obs=%b exp=%b", i, obs, exp_v);
      end
      step();
    end
    checks++;
    if (det_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL gap_det got=%0d exp=2", det_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] ex = 14'b11011101110100;
    logic [13:0] es = 14'b10001000100000;
    logic [13:0] eb = 14'b11111111111100;
    logic [13:0] ed = 14'b00000000000010;
    logic [3:0] obs, exp_v;
    int d0;
    d0 = det_cnt;
    bus.pattern = 4'b1101;
    bus.reps = 4'd2;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      exp_v = {ex[14-i], es[14-i], eb[14-i], ed[14-i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b c%0d obs=%b exp=%b", i, obs, exp_v);
      end
      step();
    end
    checks++;
    if (det_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL b2b_det got=%0d exp=3", det_cnt - d0);
    end
  endtask

  task automatic test_abort();
    logic [3:0] obs;
    bus.pattern = 4'b1101;
    bus.reps = 4'd0;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL abort c%0d obs=%b exp=0000", i, obs);
      end
      step();
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL abort_restart obs=%b exp=1110", obs);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_zero_pattern();
    logic [5:0] es = 6'b100000;
    logic [5:0] eb = 6'b111100;
    logic [5:0] ed = 6'b000010;
    logic [3:0] obs, exp_v;
    bus.pattern = 4'b0000;
    bus.reps = 4'd0;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      exp_v = {1'b0, es[6-i], eb[6-i], ed[6-i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero c%0d obs=%b exp=%b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_reps_max();
    int nbusy, nsof, dcyc, d0;
    nbusy = 0;
    nsof = 0;
    dcyc = 0;
    d0 = det_cnt;
    bus.pattern = 4'b1101;
    bus.reps = 4'd15;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (bus.busy) nbusy++;
      if (bus.sof) nsof++;
      if (bus.done && dcyc == 0) dcyc = c;
      step();
    end
    checks++;
    if (nbusy !== 64) begin
      errors++;
      $display("FAIL max_busy got=%0d exp=64", nbusy);
    end
    checks++;
    if (nsof !== 16) begin
      errors++;
      $display("FAIL max_sof got=%0d exp=16", nsof);
    end
    checks++;
    if (dcyc !== 65) begin
      errors++;
      $display("FAIL max_done got=%0d exp=65", dcyc);
    end
    checks++;
    if (det_cnt - d0 !== 16) begin
      errors++;
      $display("FAIL max_det got=%0d exp=16", det_cnt - d0);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [5:0] ex = 6'b110100;
    logic [5:0] es = 6'b100000;
    logic [5:0] eb = 6'b111100;
    logic [5:0] ed = 6'b000010;
    logic [3:0] obs, exp_v;
    bus.pattern = 4'b1101;
    bus.reps = 4'd0;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) step();
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL hold_idle obs=%b exp=0000", obs);
    end
    step();
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL hold_restart obs=%b exp=1110", obs);
    end
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset obs=%b exp=0000", obs);
    end
    bus.start = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    obs = {bus.x_out, bus.sof, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset obs=%b exp=0000", obs);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      obs = {bus.x_out, bus.sof, bus.busy, bus.done};
      exp_v = {ex[6-i], es[6-i], eb[6-i], ed[6-i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rerun c%0d obs=%b exp=%b", i, obs, exp_v);
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    det_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern = '0;
    bus.reps = '0;
    bus.gap = '0;
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_abort();
    test_zero_pattern();
    test_reps_max();
    test_hold_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
